// File: rtl/fifo_stream_feeder.sv
// fifo_stream_feeder: streams scratchpad rows into a PE input FIFO.
// A two-entry skid buffer absorbs the one-cycle read latency, so the block
// can issue one read and complete one push in the same cycle when the FIFO
// is accepting data.
module fifo_stream_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int PAR_WRITE  = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic                            abort,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [LEN_WIDTH-1:0]            length,
  output logic                            mem_ren,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] mem_rdata,
  output logic                            fifo_wen,
  output logic [PAR_WRITE*DATA_WIDTH-1:0] fifo_din,
  input  logic                            fifo_full,
  output logic                            busy,
  output logic                            done
);

  localparam int ROW_W = PAR_WRITE * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LEN_WIDTH-1:0]  rd_left;
  logic [LEN_WIDTH-1:0]  wr_left;
  logic [1:0]            occ;
  logic                  inflight;
  logic [ROW_W-1:0]      skid0;
  logic [ROW_W-1:0]      skid1;
  logic                  pop;
  logic                  issue;
  logic [1:0]            occ_after_pop;
  logic [1:0]            demand;
  logic                  kill;

  // Handshake decisions: push the oldest entry, then issue a read only if
  // the skid buffer can still hold everything already requested.
  always_comb begin
    pop           = (state == RUN) && (occ != 2'd0) && !fifo_full;
    occ_after_pop = occ - {1'b0, pop};
    demand        = occ_after_pop + {1'b0, inflight};
    issue         = (state == RUN) && (rd_left != '0) && (demand < 2'd2);
    kill          = abort && (state != IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort wins over start and over completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!abort && start) state_nxt = (length == '0) ? DONE : RUN;
      RUN: begin
        if (abort)                                      state_nxt = IDLE;
        else if (pop && (wr_left == LEN_WIDTH'(1)))     state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; fifo_din is forced to zero when the skid buffer is empty so the
  // data registers themselves need no reset.
  always_comb begin
    mem_ren  = issue;
    mem_addr = rd_addr;
    fifo_wen = pop;
    fifo_din = (occ != 2'd0) ? skid0 : '0;
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  // Address and beat counters; loaded on an accepted start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_addr <= '0;
      rd_left <= '0;
      wr_left <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      rd_addr <= base_addr;
      rd_left <= length;
      wr_left <= length;
    end else begin
      if (issue) begin
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
        rd_left <= rd_left - LEN_WIDTH'(1);
      end
      if (pop) wr_left <= wr_left - LEN_WIDTH'(1);
    end
  end

  // Skid occupancy and read-in-flight flag; abort drops any returning data.
  always_ff @(posedge clk) begin
    if (!rstn || kill) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      occ      <= occ_after_pop + {1'b0, inflight};
      inflight <= issue;
    end
  end

  // Skid data: shift on pop, then land returning data in the first free slot.
  always_ff @(posedge clk) begin
    if (pop) skid0 <= skid1;
    if (inflight) begin
      if (occ_after_pop == 2'd0) skid0 <= mem_rdata;
      else                       skid1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fifo_stream_feeder.sv
// Directed bench for fifo_stream_feeder: cycle-exact timing, backpressure,
// zero length, address wrap, abort, mid-run reset and a two-word-row build.
module tb_fifo_stream_feeder;

  logic        clk = 1'b0;
  logic        rstn, start, abort, fifo_full;
  logic [7:0]  base_addr, length;
  logic        mem_ren, fifo_wen, busy, done;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata, fifo_din;
  logic [15:0] mem [256];

  // Second instance with two words per row.
  logic        start2;
  logic [7:0]  base2, len2;
  logic        ren2, wen2, busy2, done2, full2;
  logic [7:0]  addr2;
  logic [31:0] rdata2, din2;
  logic [31:0] fq [$];
  int          fcount = 0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_stream_feeder #(.DATA_WIDTH(16), .PAR_WRITE(1), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .fifo_wen(fifo_wen), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .busy(busy), .done(done)
  );

  fifo_stream_feeder #(.DATA_WIDTH(16), .PAR_WRITE(2), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .abort(1'b0),
    .base_addr(base2), .length(len2),
    .mem_ren(ren2), .mem_addr(addr2), .mem_rdata(rdata2),
    .fifo_wen(wen2), .fifo_din(din2), .fifo_full(full2),
    .busy(busy2), .done(done2)
  );

  // Synchronous-read scratchpads: row k holds 0x1000+k (and {A0kk,B0kk}).
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr];
    if (ren2)    rdata2    <= {8'hA0, addr2, 8'hB0, addr2};
  end

  // Depth-4 FIFO model for the two-word build.
  assign full2 = (fcount >= 4);
  always @(posedge clk) begin
    if (wen2 && !full2) begin
      fq.push_back(din2);
      fcount <= fcount + 1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({mem_ren, mem_addr, fifo_wen, fifo_din, busy, done} !== 28'd0) begin
        miscompares++;
        $display("FAIL reset c%0d: got %h want 0", c,
                 {mem_ren, mem_addr, fifo_wen, fifo_din, busy, done});
      end
      next_cycle();
    end
    rstn = 1'b1;
  endtask

  // Clean transfer with the FIFO never full: exact cycle timing.
  task automatic run_clean(input logic [7:0] b, input logic [7:0] n, input string name);
    logic [3:0] got, exp;
    logic [7:0] a;
    start = 1'b1; base_addr = b; length = n;
    for (int c = 0; c <= int'(n) + 4; c++) begin
      if (c == 1) begin start = 1'b0; base_addr = 8'h00; length = 8'h00; end
      @(negedge clk);
      got = {mem_ren, fifo_wen, done, busy};
      exp = {(c >= 1 && c <= int'(n)), (c >= 3 && c <= int'(n) + 2),
             (c == int'(n) + 3), (c >= 1 && c <= int'(n) + 3)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s ctl c%0d: ren/wen/done/busy got %b want %b", name, c, got, exp);
      end
      if (exp[3]) begin
        a = b + 8'(c - 1);
        vectors++;
        if (mem_addr !== a) begin
          miscompares++;
          $display("FAIL %s addr c%0d: got %h want %h", name, c, mem_addr, a);
        end
      end
      if (exp[2]) begin
        a = b + 8'(c - 3);
        vectors++;
        if (fifo_din !== {8'h10, a}) begin
          miscompares++;
          $display("FAIL %s din c%0d: got %h want %h", name, c, fifo_din, {8'h10, a});
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_basic();
    run_clean(8'h10, 8'd4, "basic");
  endtask

  task automatic test_backpressure();
    int issued = 0, pushed = 0, done_cnt = 0, done_cyc = -1;
    logic [7:0] b = 8'h30;
    start = 1'b1; base_addr = b; length = 8'd6;
    for (int c = 0; c < 25; c++) begin
      if (c == 1) start = 1'b0;
      fifo_full = (c >= 3 && c <= 8);
      @(negedge clk);
      if (fifo_full) begin
        vectors++;
        if (fifo_wen !== 1'b0) begin
          miscompares++;
          $display("FAIL bp wen_while_full c%0d: got %b want 0", c, fifo_wen);
        end
      end
      if (mem_ren) begin
        vectors++;
        if (mem_addr !== b + 8'(issued)) begin
          miscompares++;
          $display("FAIL bp addr c%0d: got %h want %h", c, mem_addr, b + 8'(issued));
        end
        issued++;
      end
      if (fifo_wen) begin
        vectors++;
        if (fifo_din !== {8'h10, b + 8'(pushed)}) begin
          miscompares++;
          $display("FAIL bp din c%0d: got %h want %h", c, fifo_din, {8'h10, b + 8'(pushed)});
        end
        pushed++;
      end
      if (issued - pushed > 2) begin
        miscompares++;
        $display("FAIL bp outstanding c%0d: got %0d want <=2", c, issued - pushed);
      end
      if (c == 8) begin
        vectors++;
        if (issued != 2) begin
          miscompares++;
          $display("FAIL bp stall_reads: got %0d want 2", issued);
        end
      end
      if (done) begin done_cnt++; done_cyc = c; end
      next_cycle();
    end
    fifo_full = 1'b0;
    vectors++;
    if (pushed != 6 || issued != 6) begin
      miscompares++;
      $display("FAIL bp counts: got pushed %0d issued %0d want 6 6", pushed, issued);
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != 15) begin
      miscompares++;
      $display("FAIL bp done: got %0d pulses at c%0d want 1 at c15", done_cnt, done_cyc);
    end
  endtask

  task automatic test_len_zero_wrap();
    logic [2:0] got, exp;
    start = 1'b1; base_addr = 8'h33; length = 8'd0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) start = 1'b0;
      @(negedge clk);
      got = {mem_ren, done, busy};
      exp = {1'b0, (c == 1), (c == 1)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL len0 c%0d: ren/done/busy got %b want %b", c, got, exp);
      end
      next_cycle();
    end
    run_clean(8'hFE, 8'd3, "wrap");
  endtask

  task automatic test_abort();
    logic [3:0] got;
    start = 1'b1; base_addr = 8'h20; length = 8'd8;
    for (int c = 0; c < 11; c++) begin
      if (c == 1) start = 1'b0;
      abort = (c == 4);
      @(negedge clk);
      got = {mem_ren, fifo_wen, done, busy};
      if (c >= 5) begin
        vectors++;
        if (got !== 4'b0000) begin
          miscompares++;
          $display("FAIL abort idle c%0d: ren/wen/done/busy got %b want 0000", c, got);
        end
      end else begin
        vectors++;
        if (done !== 1'b0) begin
          miscompares++;
          $display("FAIL abort done c%0d: got %b want 0", c, done);
        end
      end
      next_cycle();
    end
    abort = 1'b0;
    run_clean(8'h40, 8'd2, "abort_restart");
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; base_addr = 8'h50; length = 8'd4;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) start = 1'b0;
      fifo_full = (c >= 3 && c <= 5);
      rstn = (c != 5);
      @(negedge clk);
      if (c == 5) begin
        vectors++;
        if ({mem_ren, fifo_wen, fifo_din} !== {2'b00, 16'h1050}) begin
          miscompares++;
          $display("FAIL rstmid stalled: got %b %b %h want 0 0 1050", mem_ren, fifo_wen, fifo_din);
        end
      end
      if (c >= 6) begin
        vectors++;
        if ({mem_ren, mem_addr, fifo_wen, fifo_din, busy, done} !== 28'd0) begin
          miscompares++;
          $display("FAIL rstmid zero c%0d: got %h want 0", c,
                   {mem_ren, mem_addr, fifo_wen, fifo_din, busy, done});
        end
      end
      next_cycle();
    end
    fifo_full = 1'b0; rstn = 1'b1;
    run_clean(8'h10, 8'd4, "rst_restart");
  endtask

  task automatic test_par_write2();
    int done_cyc = -1;
    logic [7:0] a;
    start2 = 1'b1; base2 = 8'h07; len2 = 8'd3;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) start2 = 1'b0;
      @(negedge clk);
      if (done2 && done_cyc < 0) done_cyc = c;
      next_cycle();
    end
    vectors++;
    if (done_cyc != 6) begin
      miscompares++;
      $display("FAIL pw2 done: got c%0d want c6", done_cyc);
    end
    vectors++;
    if (fq.size() != 3) begin
      miscompares++;
      $display("FAIL pw2 count: got %0d want 3", fq.size());
    end
    for (int k = 0; k < 3; k++) begin
      a = 8'h07 + 8'(k);
      vectors++;
      if (k >= fq.size()) begin
        miscompares++;
        $display("FAIL pw2 row%0d: missing want %h", k, {8'hA0, a, 8'hB0, a});
      end else if (fq[k] !== {8'hA0, a, 8'hB0, a}) begin
        miscompares++;
        $display("FAIL pw2 row%0d: got %h want %h", k, fq[k], {8'hA0, a, 8'hB0, a});
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);
    rstn = 1'b0; start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
    base_addr = 8'h00; length = 8'h00;
    start2 = 1'b0; base2 = 8'h00; len2 = 8'h00;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero_wrap();
    test_abort();
    test_reset_mid_run();
    test_par_write2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
